result_collector: RTL
=====================

# result_collector

Write-back end of the multiplier array: gathers the per-lane product words, one lane word per multiplier, and writes them one word per cycle into a result RAM at consecutive addresses. It sits after the multipliers, opposite `dispatcher`. It drives the `stall_word` that `dispatcher` consumes, so a lane is stalled while its captured product still awaits write-back. It counts results and flags the end of the conv layer's write-back.

## Interface
Parameters:
- `log_n_mul`, 5, log2 of lane count N
- `log_bit_width`, 5, log2 of data width W
- `ctrl_bit`, 1, control bits per lane word; MSB of each lane word is the valid flag
- `log_ram_size`, 16, result RAM address width
- `max_n_results`, 32, width of result counter

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `mult_out`  in  N*(W+ctrl_bit)  lane i at bits `[i*(W+ctrl_bit) +: W+ctrl_bit]`, i.e. `{valid, data[W-1:0]}`
- `load_n_res`  in  1  load result count and start collection
- `init_n_results`  in  max_n_results  number of results to write
- `load_base_addr`  in  1  load write base address
- `init_base_addr`  in  log_ram_size  first RAM address
- `stall_word`  out  N  bit i = lane i must not receive a new operation
- `ram_we`  out  1  RAM write strobe
- `ram_addr`  out  log_ram_size  RAM write address
- `ram_wdata`  out  W  RAM write data (valid flag stripped)
- `end_collect`  out  1  all results written
- `overrun_err`  out  1  sticky, valid word arrived at occupied lane

## Operation
- State machine `IDLE` → `COLLECT` → `DONE`. Reset enters `IDLE`.
- `load_n_res` in any state sets `rem` = `init_n_results`, clears all `hold_valid`, clears `end_collect` and `overrun_err`, and goes to `COLLECT`. If `init_n_results`==0 it goes to `DONE` instead.
- `load_base_addr` loads `wr_addr`. If both loads are high in the same cycle, both take effect.
- Capture happens in `COLLECT` only. Lane i with valid=1 and pre-edge `hold_valid[i]`==0 stores its data into `hold[i]` and sets `hold_valid[i]`.
- Drain happens in `COLLECT` only. The selected lane j is the first `hold_valid` lane at or after `rr` in round-robin order, wrapping mod N. At the edge:
  - `ram_we`←1, `ram_wdata`←`hold[j]`, `ram_addr`←`wr_addr`
  - `hold_valid[j]`←0, `wr_addr`←`wr_addr`+1 (wraps mod 2^log_ram_size)
  - `rem`←`rem`−1, `rr`←(j+1) mod N
- If no lane is held, `ram_we`←0 and `ram_addr`/`ram_wdata` hold their values.
- A lane cleared at an edge can capture again only from the next edge. A same-edge clear and capture never happen on one lane.
- A valid word at a lane with `hold_valid`=1 is dropped and sets `overrun_err` (see Configuration).
- The write that brings `rem` to 0 moves the FSM to `DONE` at that same edge. Entering `DONE` clears all `hold_valid`, sets `end_collect`, and ignores further lane words.
- `stall_word` = `hold_valid` OR {N{state≠`COLLECT`}}.
- Valid flags in `IDLE` and `DONE` are ignored and do not set `overrun_err`.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `end_collect`=0, `overrun_err`=0, `stall_word`=all ones (state `IDLE`). Also `rem`=0, `wr_addr`=0, `rr`=0, `hold_valid`=0.
- All outputs are registered or decoded from registers only; there is no combinational path from inputs.
- Latency: a word captured at edge k is written at the earliest at edge k+1, so `ram_we` is high during cycle k+1.
- Throughput is one RAM write per cycle. With M lanes held, drain takes M cycles in round-robin order.
- `stall_word[i]` rises the cycle after capture and falls the cycle after that lane is drained.
- `end_collect` rises in the same cycle as the final `ram_we` pulse.
- Reset asserted mid-`COLLECT` returns everything to reset values immediately. Held words are lost.

## Configuration
- `RESULT_COLLECTOR_OVERRUN_DET_EN` defined: the overrun detector is built and `overrun_err` is sticky as described.
- Not defined: `overrun_err` is tied to 0 and the detector logic is omitted. Dropping behaviour is unchanged.

## Test plan
Bench configuration: `log_n_mul`=2 (N=4), `log_bit_width`=3 (W=8).
- Reset, then no loads → `stall_word`=4'b1111, `ram_we`=0, `end_collect`=0.
- Load base 0x0010 and 4 results, then apply valid data 0xA0..0xA3 on lanes 0..3 for one cycle → four writes on consecutive cycles to addresses 0x10..0x13 with data A0,A1,A2,A3. `end_collect` rises with the 4th write, and `stall_word` returns to 1111.
- Load 2 results, then valid on lane 2 (0x55), then one cycle later lane 1 (0x66) → writes 55 then 66 (`rr` wraps). `stall_word[2]` is high for exactly 1 cycle.
- Lane 0 valid on two consecutive cycles with 0x11 then 0x22, while lanes 1–3 are also held → 0x22 is dropped and `overrun_err`=1 (0 when the macro is undefined).
- Base 0xFFFF with 2 results → writes go to 0xFFFF then 0x0000.
- Load 0 results → `DONE` next cycle, `end_collect`=1, no `ram_we`. Assert `rst` mid-`COLLECT` → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/result_collector_if.sv
// result_collector_if: lane-word input, load controls and RAM write port of
// the result collector. master = surrounding datapath, slave = collector.
interface result_collector_if #(
  parameter int log_n_mul     = 5,
  parameter int log_bit_width = 5,
  parameter int ctrl_bit      = 1,
  parameter int log_ram_size  = 16,
  parameter int max_n_results = 32
);
  localparam int N  = 1 << log_n_mul;
  localparam int W  = 1 << log_bit_width;
  localparam int LW = W + ctrl_bit;

  logic [N*LW-1:0]          mult_out;
  logic                     load_n_res;
  logic [max_n_results-1:0] init_n_results;
  logic                     load_base_addr;
  logic [log_ram_size-1:0]  init_base_addr;
  logic [N-1:0]             stall_word;
  logic                     ram_we;
  logic [log_ram_size-1:0]  ram_addr;
  logic [W-1:0]             ram_wdata;
  logic                     end_collect;
  logic                     overrun_err;

  modport master (
    output mult_out, load_n_res, init_n_results, load_base_addr, init_base_addr,
    input  stall_word, ram_we, ram_addr, ram_wdata, end_collect, overrun_err
  );

  modport slave (
    input  mult_out, load_n_res, init_n_results, load_base_addr, init_base_addr,
    output stall_word, ram_we, ram_addr, ram_wdata, end_collect, overrun_err
  );
endinterface

// File: rtl/result_collector.sv
// result_collector: captures per-lane product words, drains them one per cycle
// in round-robin order into a result RAM at consecutive addresses, stalls lanes
// whose word is still pending, and flags the end of the layer's write-back.
// Optional macro RESULT_COLLECTOR_OVERRUN_DET_EN builds the sticky overrun
// detector; without it overrun_err is tied low (drop behaviour is identical).
module result_collector #(
  parameter int log_n_mul     = 5,
  parameter int log_bit_width = 5,
  parameter int ctrl_bit      = 1,
  parameter int log_ram_size  = 16,
  parameter int max_n_results = 32
) (
  input logic clk,
  input logic rst,
  result_collector_if.slave bus
);
  localparam int N  = 1 << log_n_mul;
  localparam int W  = 1 << log_bit_width;
  localparam int LW = W + ctrl_bit;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [N-1:0]             hold_valid_q, hold_valid_d;
  logic [W-1:0]             hold_q [N];
  logic [W-1:0]             hold_d [N];
  logic [max_n_results-1:0] rem_q, rem_d;
  logic [log_ram_size-1:0]  wr_addr_q, wr_addr_d;
  logic [log_n_mul-1:0]     rr_q, rr_d;
  logic                     ram_we_q, ram_we_d;
  logic [log_ram_size-1:0]  ram_addr_q, ram_addr_d;
  logic [W-1:0]             ram_wdata_q, ram_wdata_d;
  logic                     end_collect_q, end_collect_d;

  logic [N-1:0]             lane_valid;
  logic [W-1:0]             lane_data [N];
  logic                     sel_found;
  logic [log_n_mul-1:0]     sel_idx;

  // Split each lane word into its valid flag (MSB) and data field.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      lane_valid[i] = bus.mult_out[i*LW + LW - 1];
      lane_data[i]  = bus.mult_out[i*LW +: W];
    end
  end

  // Round-robin pick: first held lane at or after rr, wrapping mod N.
  always_comb begin
    logic [log_n_mul-1:0] idx;
    idx       = '0;
    sel_found = 1'b0;
    sel_idx   = rr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = rr_q + k[log_n_mul-1:0];
      if (!sel_found && hold_valid_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Next-state: load handling, lane capture, one drain per cycle, completion.
  always_comb begin
    state_d       = state_q;
    hold_valid_d  = hold_valid_q;
    hold_d        = hold_q;
    rem_d         = rem_q;
    wr_addr_d     = wr_addr_q;
    rr_d          = rr_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    end_collect_d = end_collect_q;

    if (bus.load_n_res) begin
      rem_d        = bus.init_n_results;
      hold_valid_d = '0;
      if (bus.init_n_results == '0) begin
        state_d       = DONE;
        end_collect_d = 1'b1;
      end else begin
        state_d       = COLLECT;
        end_collect_d = 1'b0;
      end
    end else if (state_q == COLLECT) begin
      // Capture tests the pre-edge hold_valid, so a lane drained this edge
      // cannot recapture until the next one.
      for (int unsigned i = 0; i < N; i++) begin
        if (lane_valid[i] && !hold_valid_q[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_d[i]       = lane_data[i];
        end
      end
      if (sel_found) begin
        ram_we_d              = 1'b1;
        ram_wdata_d           = hold_q[sel_idx];
        ram_addr_d            = wr_addr_q;
        hold_valid_d[sel_idx] = 1'b0;
        wr_addr_d             = wr_addr_q + log_ram_size'(1);
        rem_d                 = rem_q - max_n_results'(1);
        rr_d                  = sel_idx + log_n_mul'(1);
        if (rem_q == max_n_results'(1)) begin
          state_d       = DONE;
          hold_valid_d  = '0;
          end_collect_d = 1'b1;
        end
      end
    end

    if (bus.load_base_addr) begin
      wr_addr_d = bus.init_base_addr;
    end
  end

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_valid_q  <= '0;
      hold_q        <= '{default: '0};
      rem_q         <= '0;
      wr_addr_q     <= '0;
      rr_q          <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      end_collect_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      hold_q        <= hold_d;
      rem_q         <= rem_d;
      wr_addr_q     <= wr_addr_d;
      rr_q          <= rr_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      end_collect_q <= end_collect_d;
    end
  end

`ifdef RESULT_COLLECTOR_OVERRUN_DET_EN
  logic overrun_q;
  logic overrun_hit;

  // A valid word reaching a still-occupied lane while collecting is an overrun.
  always_comb begin
    overrun_hit = (state_q == COLLECT) && !bus.load_n_res &&
                  (|(lane_valid & hold_valid_q));
  end

  // Sticky overrun flag, cleared only by reset or a new result-count load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (bus.load_n_res) begin
      overrun_q <= 1'b0;
    end else if (overrun_hit) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.overrun_err = overrun_q;
`else
  assign bus.overrun_err = 1'b0;
`endif

  assign bus.stall_word  = hold_valid_q | {N{state_q != COLLECT}};
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.end_collect = end_collect_q;
endmodule
